// File: rtl/ddr_rx_gearbox.sv
// DDR receive gearbox: captures a beat on each clock edge, packs BEATS beats into
// one word and queues the words in a small FIFO behind a valid/ready port.
module ddr_rx_gearbox #(
  parameter int WIDTH      = 8,
  parameter int BEATS      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic                             frame_start,
  input  logic [WIDTH-1:0]                 ddr_in,
  output logic [WIDTH*BEATS-1:0]           m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             overflow,
  input  logic                             overflow_clr,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

  localparam int PAIRS = BEATS / 2;
  localparam int DW    = WIDTH * BEATS;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int LW    = $clog2(FIFO_DEPTH + 1);
  localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CW-1:0] LAST_SLOT  = CW'(PAIRS - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  logic [WIDTH-1:0] pos_hold_r, neg_hold_r;
  logic             en_q_r, fs_q_r;
  logic [CW-1:0]    cnt_r;
  logic [DW-1:0]    acc_r;
  logic [DW-1:0]    mem_r [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic [DW-1:0]    m_data_r;
  logic             m_valid_r, overflow_r;

  logic [2*WIDTH-1:0] pair_s;
  logic [CW-1:0]      slot_s, cnt_next_s;
  logic [DW-1:0]      word_s, acc_next_s, head_next_s;
  logic               push_s, pop_s, full_s, push_ok_s, drop_s;
  logic [LW-1:0]      level_next_s;
  logic [PW-1:0]      rd_ptr_next_s;

  // Rising-edge beat capture and qualifier registration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_hold_r <= {WIDTH{1'b0}};
      en_q_r     <= 1'b0;
      fs_q_r     <= 1'b0;
    end else begin
      pos_hold_r <= ddr_in;
      en_q_r     <= enable;
      fs_q_r     <= frame_start & enable;
    end
  end

  // Falling-edge beat capture, qualified by the enable sampled at the preceding posedge
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_hold_r <= {WIDTH{1'b0}};
    end else if (en_q_r) begin
      neg_hold_r <= ddr_in;
    end else begin
      neg_hold_r <= neg_hold_r;
    end
  end

  // Pair placement: a frame start discards the partial word and restarts at slot 0
  always_comb begin
    pair_s = {neg_hold_r, pos_hold_r};
    slot_s = fs_q_r ? {CW{1'b0}} : cnt_r;
    word_s = fs_q_r ? {DW{1'b0}} : acc_r;
    word_s[int'(slot_s)*2*WIDTH +: 2*WIDTH] = pair_s;
    push_s = en_q_r && (slot_s == LAST_SLOT);
    if (!en_q_r) begin
      cnt_next_s = cnt_r;
      acc_next_s = acc_r;
    end else if (push_s) begin
      cnt_next_s = {CW{1'b0}};
      acc_next_s = {DW{1'b0}};
    end else begin
      cnt_next_s = slot_s + CW'(1);
      acc_next_s = word_s;
    end
  end

  // FIFO control; the head register is precomputed so m_data stays registered
  always_comb begin
    pop_s     = m_valid_r && m_ready;
    full_s    = (level_r == FULL_LEVEL);
    push_ok_s = push_s && (!full_s || pop_s);
    drop_s    = push_s && full_s && !pop_s;
    case ({push_ok_s, pop_s})
      2'b10:   level_next_s = level_r + LW'(1);
      2'b01:   level_next_s = level_r - LW'(1);
      default: level_next_s = level_r;
    endcase
    rd_ptr_next_s = pop_s ? rd_ptr_r + PW'(1) : rd_ptr_r;
    if (level_next_s == {LW{1'b0}}) begin
      head_next_s = {DW{1'b0}};
    end else if (push_ok_s && (rd_ptr_next_s == wr_ptr_r)) begin
      head_next_s = word_s;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Packing state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
      acc_r <= {DW{1'b0}};
    end else begin
      cnt_r <= cnt_next_s;
      acc_r <= acc_next_s;
    end
  end

  // FIFO storage, pointers, registered outputs and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {DW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      level_r    <= {LW{1'b0}};
      m_data_r   <= {DW{1'b0}};
      m_valid_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= word_s;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      rd_ptr_r   <= rd_ptr_next_s;
      level_r    <= level_next_s;
      m_data_r   <= head_next_s;
      m_valid_r  <= (level_next_s != {LW{1'b0}});
      overflow_r <= drop_s ? 1'b1 : (overflow_clr ? 1'b0 : overflow_r);
    end
  end

  assign m_data     = m_data_r;
  assign m_valid    = m_valid_r;
  assign overflow   = overflow_r;
  assign fifo_level = level_r;

endmodule

// File: tb/tb_ddr_rx_gearbox.sv
// Scoreboard bench for ddr_rx_gearbox: stimulus queues expected words, a monitor
// pops and compares them on every accepted handshake.
module tb_ddr_rx_gearbox;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        frame_start = 1'b0;
  logic [7:0]  ddr_in = 8'h00;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        overflow;
  logic        overflow_clr = 1'b0;
  logic [2:0]  fifo_level;

  int tests = 0;
  int fails = 0;
  int max_level = 0;
  logic [31:0] exp_q[$];

  ddr_rx_gearbox #(.WIDTH(8), .BEATS(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start),
    .ddr_in(ddr_in), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .overflow(overflow), .overflow_clr(overflow_clr), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at negedge+2; drives one enabled/disabled cycle with its two beats.
  task automatic drive(input logic en, input logic fs, input logic [7:0] rise, input logic [7:0] fall);
    enable = en;
    frame_start = fs;
    ddr_in = rise;
    @(posedge clk);
    #2 ddr_in = fall;
    @(negedge clk);
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'hEE, 8'hFF);
  endtask

  task automatic send_word(input logic [31:0] w);
    drive(1'b1, 1'b1, w[7:0], w[15:8]);
    drive(1'b1, 1'b0, w[23:16], w[31:24]);
  endtask

  task automatic drain(input string name);
    m_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle();
    idle();
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: samples just before each posedge and scores accepted words
  initial begin
    logic [31:0] w;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) begin
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        if (m_valid && m_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_word: got %0h expected none", m_data);
          end else begin
            w = exp_q.pop_front();
            if (m_data !== w) begin
              fails++;
              $display("FAIL word_data: got %0h expected %0h", m_data, w);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] w;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_valid", 64'(m_valid), 64'd0);
    chk("reset_data", 64'(m_data), 64'd0);
    chk("reset_level", 64'(fifo_level), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    #20 rst_n = 1'b1;
    @(negedge clk);
    #2;

    // Basic packing and latency
    m_ready = 1'b1;
    exp_q.push_back(32'h44332211);
    drive(1'b1, 1'b1, 8'h11, 8'h22);
    drive(1'b1, 1'b0, 8'h33, 8'h44);
    chk("basic_not_early", 64'(m_valid), 64'd0);
    idle();
    chk("basic_valid", 64'(m_valid), 64'd1);
    chk("basic_data", 64'(m_data), 64'h44332211);
    idle();
    chk("basic_one_cycle", 64'(m_valid), 64'd0);
    chk("basic_empty_data", 64'(m_data), 64'd0);
    drain("basic_drain");

    // Enable gaps with garbage on the bus
    exp_q.push_back(32'h44332211);
    drive(1'b1, 1'b1, 8'h11, 8'h22);
    idle();
    idle();
    drive(1'b1, 1'b0, 8'h33, 8'h44);
    chk("gap_not_early", 64'(m_valid), 64'd0);
    idle();
    chk("gap_valid", 64'(m_valid), 64'd1);
    chk("gap_data", 64'(m_data), 64'h44332211);
    drain("gap_drain");

    // Realignment discards the partial word
    exp_q.push_back(32'h04030201);
    drive(1'b1, 1'b1, 8'hAA, 8'hBB);
    drive(1'b1, 1'b1, 8'h01, 8'h02);
    drive(1'b1, 1'b0, 8'h03, 8'h04);
    idle();
    chk("realign_data", 64'(m_data), 64'h04030201);
    drain("realign_drain");

    // Overflow: four words fill, fifth dropped while overflow_clr is high
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w = 32'h10203040 + 32'(k) * 32'h01010101;
      exp_q.push_back(w);
      send_word(w);
    end
    send_word(32'hDEADBEEF);
    overflow_clr = 1'b1;
    idle();
    overflow_clr = 1'b0;
    chk("ovf_level_full", 64'(fifo_level), 64'd4);
    chk("ovf_drop_beats_clr", 64'(overflow), 64'd1);
    chk("ovf_head_intact", 64'(m_data), 64'h10203040);
    exp_q.push_back(32'hCAFEF00D);
    send_word(32'hCAFEF00D);
    m_ready = 1'b1;
    idle();
    chk("ovf_push_pop_level", 64'(fifo_level), 64'd4);
    chk("ovf_push_pop_head", 64'(m_data), 64'h11213141);
    drain("ovf_drain");
    chk("ovf_still_set", 64'(overflow), 64'd1);
    overflow_clr = 1'b1;
    idle();
    overflow_clr = 1'b0;
    chk("ovf_cleared", 64'(overflow), 64'd0);

    // Reset mid-stream: queued word and partial word lost
    m_ready = 1'b0;
    send_word(32'h55667788);
    idle();
    drive(1'b1, 1'b1, 8'h99, 8'h9A);
    chk("pre_reset_level", 64'(fifo_level), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", 64'(m_valid), 64'd0);
    chk("midreset_level", 64'(fifo_level), 64'd0);
    chk("midreset_data", 64'(m_data), 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #2;
    m_ready = 1'b1;
    idle();
    chk("post_reset_empty", 64'(m_valid), 64'd0);
    exp_q.push_back(32'hA1B2C3D4);
    send_word(32'hA1B2C3D4);
    drain("post_reset_drain");

    // Random back-pressure over 100 words
    max_level = 0;
    for (int k = 0; k < 100; k++) begin
      w = $urandom;
      exp_q.push_back(w);
      m_ready = (fifo_level >= 3'd3) ? 1'b1 : ($urandom_range(3) != 0);
      drive(1'b1, 1'b1, w[7:0], w[15:8]);
      m_ready = (fifo_level >= 3'd3) ? 1'b1 : ($urandom_range(3) != 0);
      drive(1'b1, 1'b0, w[23:16], w[31:24]);
      if ($urandom_range(3) == 0) begin
        m_ready = (fifo_level >= 3'd3) ? 1'b1 : ($urandom_range(1) != 0);
        idle();
      end
    end
    drain("random_drain");
    chk("random_no_overflow", 64'(overflow), 64'd0);
    chk("random_level_bound", 64'(max_level <= 4), 64'd1);
    chk("final_empty_data", 64'(m_data), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ddr_rx_gearbox.md
# ddr_rx_gearbox

Double-data-rate receive gearbox. Captures a WIDTH-bit bus on both clock edges, as produced by the dual-edge register stage, and packs BEATS consecutive half-cycle beats into one wide word. Words are buffered in a small FIFO and presented on a valid/ready interface at single data rate. It sits directly downstream of the dual-edge register in the register library and converts its DDR stream back into single-edge clock-domain words.

## Interface
- WIDTH, 8, bits per DDR beat
- BEATS, 4, beats per output word; even, ≥2
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2
- clk  in  1  single clock; data sampled on both edges
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  sampled at posedge n; qualifies both beats of cycle n
- frame_start  in  1  sampled at posedge n with enable; the rising beat at edge n becomes beat 0
- ddr_in  in  WIDTH  DDR data
- m_data  out  WIDTH*BEATS  FIFO head word; beat 0 in bits [WIDTH-1:0]
- m_valid  out  1  FIFO non-empty
- m_ready  in  1  consumer accepts head when m_valid & m_ready at posedge
- overflow  out  1  sticky: a completed word was dropped
- overflow_clr  in  1  synchronous clear of overflow
- fifo_level  out  $clog2(FIFO_DEPTH+1)  occupied entries

## Operation
- Clock/reset: one clock, clk. Reset rst_n is asynchronous and active-low. It clears every register, including the negedge-domain registers.
- Reset values: m_valid=0, m_data=0, overflow=0, fifo_level=0, beat counter=0, accumulator=0.
- Capture:
  - pos_hold loads ddr_in at posedge n. en_q and fs_q register enable and frame_start at the same edge.
  - neg_hold loads ddr_in at the falling edge after posedge n when en_q=1. Otherwise it holds.
- Pair formation: at posedge n+1, if en_q=1, the pair {neg_hold, pos_hold} is complete. The rising beat is the lower beat. No pair is formed when en_q=0; disabled cycles are skipped, not zero-filled.
- Packing:
  - The pair index counter cnt runs 0..BEATS/2-1. The pair is written to accumulator slot cnt, i.e. bits [(2*cnt+2)*WIDTH-1 : 2*cnt*WIDTH].
  - If fs_q=1, the pair is forced into slot 0, any partial word is discarded silently, and cnt becomes 1. When BEATS=2 the word completes immediately.
  - When the pair fills slot BEATS/2-1, the completed word (accumulator plus this pair) is pushed to the FIFO at the same edge and cnt wraps to 0.
- FIFO:
  - Push occurs on word completion; pop occurs when m_valid & m_ready.
  - Full with no pop: the pushed word is dropped and overflow is set. FIFO contents are unchanged.
  - Full with a simultaneous pop: the push is accepted and no overflow occurs; level stays FIFO_DEPTH.
  - Empty with a simultaneous push: no pop; level goes to 1.
  - m_data shows the head entry. m_data is 0 whenever the FIFO is empty.
- overflow:
  - overflow_clr=1 clears it. If a drop occurs in the same cycle as overflow_clr, the flag remains set.
  - Only rst_n and overflow_clr clear it.
- Reset mid-operation: the partial word and all FIFO contents are lost. m_valid drops asynchronously.

## Timing
- With enable held and frame_start at posedge n, beat 0 is the rising beat at edge n. The word is pushed at posedge n+BEATS/2, and m_valid is high after that edge.
- Latency is BEATS/2 cycles from the first rising beat to m_valid; there is no further bubble.
- With m_ready held high, throughput is one word per BEATS/2 enabled cycles.
- A pop at posedge k shows the next head, or 0 if empty, after edge k.
- fifo_level updates at the same edge as the push/pop.
- enable and frame_start need setup only to posedge. ddr_in must be stable around both edges.

## Test plan
- Reset/defaults: assert rst_n=0 mid-stream -> all outputs 0 immediately; after release, the first word needs a fresh frame_start-aligned sequence.
- Basic packing (WIDTH=8, BEATS=4):
  - Stimulus: frame_start at posedge 0, rising/falling beats 0x11,0x22,0x33,0x44, m_ready=1.
  - Response: m_valid rises after posedge 2 with m_data=0x44332211 for exactly one cycle.
- Enable gaps: the same beats, with enable low for two cycles between pairs -> m_data=0x44332211. The word appears two cycles later than in the basic case, with no garbage beats.
- Realignment:
  - Stimulus: frame_start at posedge 0 (pair 0xAA,0xBB), then frame_start again at posedge 1 with beats 0x01,0x02,0x03,0x04.
  - Response: only 0x04030201 is output; the 0xBBAA partial word is discarded.
- Overflow:
  - m_ready=0 and 5 words pushed -> fifo_level=4 and overflow=1; the first 4 words are intact in order.
  - Raising m_ready on the cycle the 6th word completes -> that push is accepted, with no new drop.
  - overflow_clr -> overflow=0.
- Back-pressure ordering: random m_ready over 100 random words -> output order and data match the input, fifo_level never exceeds 4, and there is no overflow while the average drain rate keeps up.
